// File: rtl/ogpu_quad_store_handshake.sv
// Quad FIFO feeding the HPS-facing quad_store PIO registers. Quads arrive over
// valid/ready and are handed to software one at a time via a four-phase req/ack.
module ogpu_quad_store_handshake #(
  parameter int FIFO_DEPTH = 8,
  parameter int X_W        = 10,
  parameter int Y_W        = 10,
  parameter int COLOR_W    = 32
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [X_W-1:0]                in_x,
  input  logic [Y_W-1:0]                in_y,
  input  logic [3:0]                    in_mask,
  input  logic [4*COLOR_W-1:0]          in_color,
  input  logic                          flush,
  output logic                          store_req,
  output logic [X_W-1:0]                store_x,
  output logic [Y_W-1:0]                store_y,
  output logic [3:0]                    store_mask,
  output logic [4*COLOR_W-1:0]          store_color,
  input  logic                          store_ack,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [31:0]                   store_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [X_W-1:0]       x;
    logic [Y_W-1:0]       y;
    logic [3:0]           mask;
    logic [4*COLOR_W-1:0] color;
  } quad_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_ACK_LOW
  } state_t;

  quad_t              mem_q [FIFO_DEPTH];
  quad_t              in_quad;
  quad_t              head_quad;
  quad_t              store_quad_q;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  state_t             state_q;
  logic               store_req_q;
  logic [31:0]        store_count_q;
  logic               push;
  logic               pop;

  assign in_quad   = '{x: in_x, y: in_y, mask: in_mask, color: in_color};
  assign head_quad = mem_q[rd_ptr_q];

  // Ready ignores a same-cycle pop so it never depends on store_ack.
  assign in_ready = (level_q != DEPTH_L) && !flush;
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == S_IDLE) && (level_q != '0) && !store_ack && !flush;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      level_d = level_q + LVL_W'(push) - LVL_W'(pop);
    end
  end

  // NOTE: the quad storage has no reset; the level and pointers alone decide
  // which entries are valid, so clearing the array would only cost logic.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_quad;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      store_req_q   <= 1'b0;
      store_quad_q  <= '0;
      store_count_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            store_quad_q <= head_quad;
            store_req_q  <= 1'b1;
            state_q      <= S_REQ;
          end
        end
        S_REQ: begin
          if (store_ack) begin
            store_req_q   <= 1'b0;
            store_count_q <= store_count_q + 32'd1;
            state_q       <= S_ACK_LOW;
          end
        end
        S_ACK_LOW: begin
          // Software must release ack before the next quad may launch.
          if (!store_ack) state_q <= S_IDLE;
        end
        default: begin
          store_req_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign store_req   = store_req_q;
  assign store_x     = store_quad_q.x;
  assign store_y     = store_quad_q.y;
  assign store_mask  = store_quad_q.mask;
  assign store_color = store_quad_q.color;
  assign fifo_level  = level_q;
  assign store_count = store_count_q;

endmodule

// File: tb/tb_ogpu_quad_store_handshake.sv
// Directed bench for ogpu_quad_store_handshake: reset, single quad, fill,
// back-to-back handshakes, flush, held ack and asynchronous reset.
module tb_ogpu_quad_store_handshake;

  logic         clk;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [9:0]   in_x;
  logic [9:0]   in_y;
  logic [3:0]   in_mask;
  logic [127:0] in_color;
  logic         flush;
  logic         store_req;
  logic [9:0]   store_x;
  logic [9:0]   store_y;
  logic [3:0]   store_mask;
  logic [127:0] store_color;
  logic         store_ack;
  logic [3:0]   fifo_level;
  logic [31:0]  store_count;

  int checks;
  int failures;
  logic [31:0] exp_count;

  ogpu_quad_store_handshake #(
    .FIFO_DEPTH(8), .X_W(10), .Y_W(10), .COLOR_W(32)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_mask(in_mask), .in_color(in_color),
    .flush(flush),
    .store_req(store_req), .store_x(store_x), .store_y(store_y),
    .store_mask(store_mask), .store_color(store_color),
    .store_ack(store_ack), .fifo_level(fifo_level), .store_count(store_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req_and_ack(input logic [9:0] exp_x, input string name);
    int n;
    n = 0;
    while (store_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (store_req !== 1'b1) begin
      failures++;
      $display("FAIL %s_launch_timeout: store_req=%b required 1", name, store_req);
    end
    checks++;
    if (store_x !== exp_x) begin
      failures++;
      $display("FAIL %s_order: store_x=%0d required %0d", name, store_x, exp_x);
    end
    store_ack = 1'b1;
    tick();
    exp_count = exp_count + 1;
    checks++;
    if (store_req !== 1'b0 || store_count !== exp_count) begin
      failures++;
      $display("FAIL %s_ack: store_req=%b count=%0d required 0/%0d", name, store_req, store_count, exp_count);
    end
    store_ack = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_mask = '0;
    in_color = '0; flush = 1'b0; store_ack = 1'b0; exp_count = '0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (store_req !== 1'b0 || fifo_level !== 4'd0 || store_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: req=%b level=%0d count=%0d required 0/0/0", store_req, fifo_level, store_count);
    end
    checks++;
    if (store_x !== 10'd0 || store_y !== 10'd0 || store_mask !== 4'd0 || store_color !== 128'd0) begin
      failures++;
      $display("FAIL reset_store_regs: x=%0d y=%0d mask=%h color=%h required all zero", store_x, store_y, store_mask, store_color);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_single_quad();
    in_valid = 1'b1; in_x = 10'd5; in_y = 10'd7; in_mask = 4'hF;
    in_color = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    tick();
    in_valid = 1'b0;
    checks++;
    if (store_req !== 1'b0 || fifo_level !== 4'd1) begin
      failures++;
      $display("FAIL single_accept: req=%b level=%0d required 0/1", store_req, fifo_level);
    end
    tick();
    checks++;
    if (store_req !== 1'b1 || fifo_level !== 4'd0) begin
      failures++;
      $display("FAIL single_launch: req=%b level=%0d required 1/0", store_req, fifo_level);
    end
    checks++;
    if (store_x !== 10'd5 || store_y !== 10'd7 || store_mask !== 4'hF ||
        store_color !== {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}) begin
      failures++;
      $display("FAIL single_payload: x=%0d y=%0d mask=%h color=%h required 5/7/f/44..11", store_x, store_y, store_mask, store_color);
    end
    store_ack = 1'b1;
    tick();
    exp_count = exp_count + 1;
    checks++;
    if (store_req !== 1'b0 || store_count !== 32'd1) begin
      failures++;
      $display("FAIL single_ack: req=%b count=%0d required 0/1", store_req, store_count);
    end
    store_ack = 1'b0;
    repeat (2) tick();
    checks++;
    if (store_req !== 1'b0 || store_x !== 10'd5 || store_count !== 32'd1) begin
      failures++;
      $display("FAIL single_hold: req=%b x=%0d count=%0d required 0/5/1", store_req, store_x, store_count);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_x = 10'(10 + i); in_mask = 4'(i);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL fill_ready_%0d: in_ready=%b required 1", i, in_ready);
      end
      tick();
    end
    in_x = 10'd99;
    #1;
    checks++;
    if (fifo_level !== 4'd8 || in_ready !== 1'b0 || store_req !== 1'b1 || store_x !== 10'd10) begin
      failures++;
      $display("FAIL fill_full: level=%0d ready=%b req=%b x=%0d required 8/0/1/10", fifo_level, in_ready, store_req, store_x);
    end
    repeat (2) tick();
    checks++;
    if (fifo_level !== 4'd8 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL fill_hold: level=%0d ready=%b required 8/0", fifo_level, in_ready);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) wait_req_and_ack(10'(10 + i), "fill_drain");
    checks++;
    if (fifo_level !== 4'd0 || store_req !== 1'b0) begin
      failures++;
      $display("FAIL fill_empty: level=%0d req=%b required 0/0", fifo_level, store_req);
    end
  endtask

  task automatic test_back_to_back();
    int rise_cycle[$];
    int seen;
    logic prev_req;
    prev_req = store_req;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (store_req === 1'b1 && prev_req !== 1'b1) begin
        rise_cycle.push_back(c);
        checks++;
        if (store_x !== 10'(100 + seen)) begin
          failures++;
          $display("FAIL b2b_order_%0d: store_x=%0d required %0d", seen, store_x, 100 + seen);
        end
        seen++;
      end
      prev_req = store_req;
      store_ack = store_req;
      in_valid = (c < 3);
      in_x = 10'(100 + c);
      tick();
    end
    in_valid = 1'b0; store_ack = 1'b0;
    tick();
    exp_count = exp_count + 3;
    checks++;
    if (seen != 3 || store_count !== exp_count) begin
      failures++;
      $display("FAIL b2b_count: launches=%0d count=%0d required 3/%0d", seen, store_count, exp_count);
    end
    for (int k = 1; k < rise_cycle.size(); k++) begin
      checks++;
      if (rise_cycle[k] - rise_cycle[k-1] < 3) begin
        failures++;
        $display("FAIL b2b_spacing_%0d: gap=%0d required >=3", k, rise_cycle[k] - rise_cycle[k-1]);
      end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_x = 10'(200 + i);
      tick();
    end
    checks++;
    if (fifo_level !== 4'd4 || store_req !== 1'b1 || store_x !== 10'd200) begin
      failures++;
      $display("FAIL flush_setup: level=%0d req=%b x=%0d required 4/1/200", fifo_level, store_req, store_x);
    end
    flush = 1'b1; in_x = 10'd250;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_ready: in_ready=%b required 0", in_ready);
    end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (fifo_level !== 4'd0 || store_req !== 1'b1 || store_x !== 10'd200) begin
      failures++;
      $display("FAIL flush_level: level=%0d req=%b x=%0d required 0/1/200", fifo_level, store_req, store_x);
    end
    store_ack = 1'b1;
    tick();
    exp_count = exp_count + 1;
    checks++;
    if (store_req !== 1'b0 || store_count !== exp_count) begin
      failures++;
      $display("FAIL flush_inflight: req=%b count=%0d required 0/%0d", store_req, store_count, exp_count);
    end
    store_ack = 1'b0;
    repeat (4) tick();
    checks++;
    if (store_req !== 1'b0 || fifo_level !== 4'd0 || store_x !== 10'd200) begin
      failures++;
      $display("FAIL flush_quiet: req=%b level=%0d x=%0d required 0/0/200", store_req, fifo_level, store_x);
    end
  endtask

  task automatic test_ack_held();
    store_ack = 1'b1;
    in_valid = 1'b1; in_x = 10'd300;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if (store_req !== 1'b0 || fifo_level !== 4'd1) begin
      failures++;
      $display("FAIL ack_held_stall: req=%b level=%0d required 0/1", store_req, fifo_level);
    end
    store_ack = 1'b0;
    tick();
    checks++;
    if (store_req !== 1'b1 || store_x !== 10'd300 || fifo_level !== 4'd0) begin
      failures++;
      $display("FAIL ack_held_launch: req=%b x=%0d level=%0d required 1/300/0", store_req, store_x, fifo_level);
    end
    wait_req_and_ack(10'd300, "ack_held");
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; in_x = 10'd400; in_y = 10'd9; in_mask = 4'h3;
    tick();
    in_x = 10'd401;
    tick();
    in_valid = 1'b0;
    checks++;
    if (store_req !== 1'b1 || store_x !== 10'd400 || fifo_level !== 4'd1 || store_count === 32'd0) begin
      failures++;
      $display("FAIL areset_setup: req=%b x=%0d level=%0d count=%0d required 1/400/1/nonzero", store_req, store_x, fifo_level, store_count);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (store_req !== 1'b0 || store_x !== 10'd0 || store_y !== 10'd0 || store_mask !== 4'd0 ||
        store_color !== 128'd0 || fifo_level !== 4'd0 || store_count !== 32'd0) begin
      failures++;
      $display("FAIL areset_immediate: req=%b x=%0d y=%0d mask=%h level=%0d count=%0d required all zero", store_req, store_x, store_y, store_mask, fifo_level, store_count);
    end
    tick();
    reset_n = 1'b1;
    repeat (2) tick();
    checks++;
    if (store_req !== 1'b0 || fifo_level !== 4'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL areset_after: req=%b level=%0d ready=%b required 0/0/1", store_req, fifo_level, in_ready);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single_quad();
    test_fill();
    test_back_to_back();
    test_flush();
    test_ack_held();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ogpu_quad_store_handshake.md
Name: ogpu_quad_store_handshake

Overview:
- Upstream feeder of the quad_store_req PIO input port.
- Accepts 2x2 pixel quads from the raster/shade pipeline over valid/ready and buffers them in a small FIFO.
- Presents one quad at a time to the HPS-facing PIO registers, using a four-phase req/ack handshake with the HPS software loop.
- store_req drives the quad_store_req PIO in_port; store_ack comes from an HPS-written output PIO in the same clk domain.

Parameters:
- FIFO_DEPTH, 8, quad buffer entries; power of two, >= 2.
- X_W, 10, quad x-coordinate width.
- Y_W, 10, quad y-coordinate width.
- COLOR_W, 32, per-pixel colour width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream quad valid.
- in_ready  out  1  block can accept a quad this cycle.
- in_x  in  X_W  quad origin x.
- in_y  in  Y_W  quad origin y.
- in_mask  in  4  per-pixel coverage mask.
- in_color  in  4*COLOR_W  pixel colours; pixel0 in the LSBs.
- flush  in  1  synchronous discard of all queued quads.
- store_req  out  1  to the quad_store_req PIO; quad presented.
- store_x  out  X_W  presented quad x.
- store_y  out  Y_W  presented quad y.
- store_mask  out  4  presented quad mask.
- store_color  out  4*COLOR_W  presented quad colours.
- store_ack  in  1  from HPS output PIO; synchronous to clk.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  queued entries, excluding the presented quad.
- store_count  out  32  completed handshakes; wraps modulo 2^32.

Behaviour:
- Reset: clk, reset_n; reset is asynchronous, active-low. All registers clear: FIFO empty, state IDLE, store_req=0, store_x/y/mask/color=0, store_count=0, fifo_level=0.
- Reset asserted mid-handshake aborts the handshake. The presented quad is lost.
- in_ready = (fifo_level != FIFO_DEPTH) && !flush. It is combinational and does not consider a same-cycle pop.
- Push occurs when in_valid && in_ready at a rising edge. Pop occurs only on the IDLE launch (below).
- Simultaneous push and pop leaves fifo_level unchanged; the FIFO is written and read correctly.
- Read/write pointers wrap modulo FIFO_DEPTH.
- flush: fifo_level becomes 0 at the next edge. A same-cycle push is refused (in_ready=0) and a same-cycle pop is suppressed. An in-flight handshake is unaffected and completes normally.
- FSM states:
  - IDLE: store_req=0. If the FIFO is non-empty, store_ack==0 and no flush, then pop the head into the store_* registers, set store_req=1, go to REQ. If store_ack==1, stay in IDLE; software has not released the previous ack.
  - REQ: store_req=1 and store_* stable. When store_ack==1: store_req<=0, store_count<=store_count+1, go to ACK_LOW.
  - ACK_LOW: store_req=0. When store_ack==0, go to IDLE.
- store_* outputs hold the last presented quad until the next launch; they are never cleared except by reset.
- Latency: a quad accepted at edge t0 into an idle, empty block gives store_req=1 after edge t1. There is no FIFO bypass.
- Minimum handshake is 3 cycles per quad (IDLE, REQ, ACK_LOW) with ack responding immediately.
- store_ack rising in IDLE or ACK_LOW, or falling in REQ, has no effect beyond the transitions listed above.
- store_count increments exactly once per REQ->ACK_LOW transition.

Test Plan:
- Reset, then one quad (x=5, y=7, mask=4'hF, colours 0x11111111..0x44444444) -> store_req=1 one cycle after accept, store_* match the input. Ack high -> store_req=0 next cycle, store_count=1. Ack low -> IDLE.
- Push FIFO_DEPTH+1 quads back-to-back with ack held low -> first quad launches. The FIFO then fills to 8 and in_ready=0 until the first handshake completes.
- 3 quads with immediate ack/release by the bench -> presented in order, each pair of consecutive store_req rising edges >= 3 cycles apart, store_count=3.
- Assert flush with 4 queued and one in REQ -> fifo_level=0 next cycle. The in-flight quad completes on ack, store_count increments by 1, and store_req stays 0 afterwards.
- Hold store_ack=1 while a quad is queued in IDLE -> no launch until ack drops. Launch then follows on the next cycle.
- Assert reset_n low while in REQ -> store_req, store_*, fifo_level and store_count read 0 immediately, without waiting for a clock edge.
